// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one shared FIFO from NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to compile in burst locking (ARB/LOCK states).
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int FIFO_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*FIFO_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   input  logic                      fifo_full,
   output logic                      write_enable,
   output logic [FIFO_W-1:0]         data_in,
   output logic [15:0]               write_count
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_cfg
      $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..15");
   end

   logic [PW-1:0] rr_ptr_r;
   logic [PW-1:0] start_s;
   logic [PW-1:0] win_s;
   logic [PW-1:0] idx_s;
   logic          found_s;
   logic          owner_hit_s;

`ifdef FIFO_ARB_BURST_EN
   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
   localparam logic [3:0] BURST_L = 4'(BURST_LEN);
   state_t        state_r;
   logic [PW-1:0] owner_r;
   logic [3:0]    count_r;
`endif

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      if (p == PW'(NUM_REQ - 1)) begin
         return '0;
      end else begin
         return p + 1'b1;
      end
   endfunction

   // Winner selection and zero-latency grant/data path.
   always_comb begin
      start_s     = rr_ptr_r;
      win_s       = '0;
      idx_s       = '0;
      grant       = '0;
      data_in     = '0;
      found_s     = |req;
      owner_hit_s = 1'b0;
      // Descending scan so the last hit written is the first one in round-robin order.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx_s = PW'((int'(start_s) + i) % NUM_REQ);
         win_s = req[idx_s] ? idx_s : win_s;
      end
`ifdef FIFO_ARB_BURST_EN
      // While locked rr_ptr already sits at owner+1, so a missing owner falls back to that search.
      if (state_r == LOCK && req[owner_r]) begin
         owner_hit_s = 1'b1;
         win_s       = owner_r;
      end else begin
         owner_hit_s = 1'b0;
      end
`endif
      if (rst || fifo_full || !found_s) begin
         grant   = '0;
         data_in = '0;
      end else begin
         grant[win_s] = 1'b1;
         data_in      = req_data[win_s*FIFO_W +: FIFO_W];
      end
      write_enable = |grant;
   end

   // Pointer, write counter and burst-lock state; everything holds while no write occurs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r    <= '0;
         write_count <= 16'h0000;
`ifdef FIFO_ARB_BURST_EN
         state_r     <= ARB;
         owner_r     <= '0;
         count_r     <= 4'd0;
`endif
      end else if (write_enable) begin
         rr_ptr_r    <= wrap_inc(win_s);
         write_count <= write_count + 16'd1;
`ifdef FIFO_ARB_BURST_EN
         if (owner_hit_s) begin
            if ((count_r + 4'd1) == BURST_L) begin
               state_r <= ARB;
               count_r <= 4'd0;
            end else begin
               count_r <= count_r + 4'd1;
            end
         end else if (BURST_L == 4'd1) begin
            state_r <= ARB;
            count_r <= 4'd0;
         end else begin
            state_r <= LOCK;
            owner_r <= win_s;
            count_r <= 4'd1;
         end
`endif
      end else begin
         rr_ptr_r    <= rr_ptr_r;
         write_count <= write_count;
      end
   end

   logic unused_s;
   assign unused_s = owner_hit_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: the driver queues expected writes/counts,
// the monitor compares them against the DUT on the falling clock edge.
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           fifo_full = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   grant;
   logic           write_enable;
   logic [W-1:0]   data_in;
   logic [15:0]    write_count;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_W(W), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
      .fifo_full(fifo_full), .write_enable(write_enable), .data_in(data_in),
      .write_count(write_count)
   );

   typedef struct packed {
      logic [N-1:0] g;
      logic [W-1:0] d;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] cnt_q[$];
   logic [W-1:0] slice_v [N];
   logic [15:0] exp_count = 16'd0;
   bit          done = 1'b0;
   int          checks = 0;
   int          errors = 0;
   exp_t        mon_e;
   logic [15:0] mon_c;

   function automatic exp_t mk(input int k);
      exp_t e;
      logic [N-1:0] one;
      one = 4'b0001;
      e.g = one << k;
      e.d = slice_v[k];
      return e;
   endfunction

   // One cycle: k >= 0 is the requester expected to be granted, chk queues a write_count check.
   task automatic step(input logic [N-1:0] r, input logic f, input logic rs, input int k, input bit chk);
      @(posedge clk);
      #1;
      req       = r;
      fifo_full = f;
      rst       = rs;
      if (chk) cnt_q.push_back(exp_count);
      if (rs) begin
         exp_count = 16'd0;
      end else if (k >= 0) begin
         exp_q.push_back(mk(k));
         exp_count = exp_count + 16'd1;
      end
   endtask

   // Monitor: sole owner of the check/error counters.
   always @(negedge clk) begin
      if (cnt_q.size() > 0) begin
         mon_c = cnt_q.pop_front();
         checks++;
         if (write_count !== mon_c) begin
            errors++;
            $display("FAIL write_count: got %h expected %h at %0t", write_count, mon_c, $time);
         end
      end
      if (rst) begin
         checks++;
         if (grant !== '0 || write_enable !== 1'b0 || data_in !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b we=%b data=%h expected all zero", grant, write_enable, data_in);
         end
      end else if (write_enable === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: grant=%b data=%h expected no write at %0t", grant, data_in, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (grant !== mon_e.g || data_in !== mon_e.d) begin
               errors++;
               $display("FAIL write: grant=%b data=%h expected grant=%b data=%h at %0t",
                        grant, data_in, mon_e.g, mon_e.d, $time);
            end
         end
      end else begin
         if (grant !== '0 || data_in !== '0) begin
            checks++;
            errors++;
            $display("FAIL idle_outputs: grant=%b data=%h expected zero with we=%b", grant, data_in, write_enable);
         end
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write: got we=%b expected grant=%b at %0t", write_enable, mon_e.g, $time);
         end
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0 || cnt_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expected 0", exp_q.size() + cnt_q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      slice_v[0] = 8'h33;
      slice_v[1] = 8'h5A;
      slice_v[2] = 8'hCC;
      slice_v[3] = 8'hA5;
      req_data = {8'hA5, 8'hCC, 8'h5A, 8'h33};

      step(4'b1111, 1'b0, 1'b1, -1, 1'b1);
      step(4'b1111, 1'b0, 1'b1, -1, 1'b1);
`ifndef FIFO_ARB_BURST_EN
      // Plain round robin over all four requesters.
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0, i % 4, 1'b0);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b1);
      // Two requesters alternate: 0x33, 0xCC, ...
      for (int i = 0; i < 4; i++) step(4'b0101, 1'b0, 1'b0, (i % 2) * 2, 1'b0);
      // Pointer now 3: requesters 0,1,3 -> 3,0,1,3.
      step(4'b1011, 1'b0, 1'b0, 3, 1'b0);
      step(4'b1011, 1'b0, 1'b0, 0, 1'b0);
      step(4'b1011, 1'b0, 1'b0, 1, 1'b0);
      step(4'b1011, 1'b0, 1'b0, 3, 1'b1);
`else
      // Burst of four per owner, alternating owners.
      for (int i = 0; i < 12; i++) step(4'b0011, 1'b0, 1'b0, (i / 4) % 2, 1'b0);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b1);
      // Lock and count survive a full cycle.
      step(4'b0011, 1'b0, 1'b1, -1, 1'b0);
      step(4'b0011, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0011, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0011, 1'b1, 1'b0, -1, 1'b1);
      step(4'b0011, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0011, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0011, 1'b0, 1'b0, 1, 1'b0);
      // Owner drops its request mid-burst: requester 2 wins the same cycle.
      step(4'b0101, 1'b0, 1'b1, -1, 1'b0);
      step(4'b0101, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0101, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0100, 1'b0, 1'b0, 2, 1'b1);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b0);
`endif
      // Full stalls a pending request without dropping it.
      step(4'b0010, 1'b1, 1'b0, -1, 1'b1);
      step(4'b0010, 1'b1, 1'b0, -1, 1'b1);
      step(4'b0010, 1'b1, 1'b0, -1, 1'b1);
      step(4'b0010, 1'b0, 1'b0, 1, 1'b1);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b1);
      // Reset in the middle of traffic, then arbitration restarts from requester 0.
      step(4'b0010, 1'b0, 1'b0, 1, 1'b0);
      step(4'b0010, 1'b0, 1'b0, 1, 1'b0);
      step(4'b1111, 1'b0, 1'b1, -1, 1'b1);
      step(4'b1111, 1'b0, 1'b1, -1, 1'b1);
      step(4'b1110, 1'b0, 1'b0, 1, 1'b1);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b1);
      // Counter wrap: 65535 writes reach 0xFFFF, one more wraps to zero.
      step(4'b0000, 1'b0, 1'b1, -1, 1'b0);
      for (int i = 0; i < 65535; i++) step(4'b0001, 1'b0, 1'b0, 0, 1'b0);
      step(4'b0001, 1'b0, 1'b0, 0, 1'b1);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b1);
      if (exp_count != 16'h0000) $display("FAIL model_wrap: got %h expected 0000", exp_count);
      step(4'b0000, 1'b0, 1'b0, -1, 1'b0);
      done = 1'b1;
   end
endmodule
